dual_port_ram_p: RTL and testbench
==================================

// Module: dual_port_ram_p
// PURPOSE
//  Parametrised simple dual-port RAM (one write port, one read port, one clock): next generation of our 16x8 dual-port RAM.
//  Adds configurable width/depth, byte-lane write enables, optional output register, selectable read-during-write mode,
//  and a post-reset hardware clear sweep with init_done status. Sits between datapath producers/consumers as scratch/line buffer.
// PARAMETERS
//  DATA_W    8     data width in bits; must be a multiple of 8
//  ADDR_W    4     address width in bits
//  DEPTH     16    number of words; 1 <= DEPTH <= 2**ADDR_W
//  OUT_REG   0     0: read latency 1 cycle; 1: extra output register, read latency 2 cycles
//  RDW_MODE  0     same-address read+write in one cycle: 0 = return old data, 1 = return new (byte-merged) data
//  CLR_VAL   0     DATA_W-bit value written to every word during the clear sweep
//  (derived) BE_W = DATA_W/8
// PORTS
//  clk         in   1        clock; all logic on rising edge
//  rst_n       in   1        synchronous active-low reset
//  we          in   1        write enable
//  wr_addr     in   ADDR_W   write address
//  be          in   BE_W     byte-lane enables; bit i gates din[8i+7:8i]
//  din         in   DATA_W   write data
//  re          in   1        read enable
//  re_addr     in   ADDR_W   read address
//  dout        out  DATA_W   read data
//  dout_valid  out  1        one-cycle pulse: dout carries data of a completed read
//  oor_err     out  1        one-cycle pulse: a port was given an address >= DEPTH (registered, aligned with read-stage 1)
//  init_done   out  1        1 = clear sweep finished, ports live
// BEHAVIOUR
//  Reset (rst_n=0 at an edge): dout=0, dout_valid=0, oor_err=0, init_done=0, all pipeline valids 0, state=CLEAR, clr_ptr=0.
//  FSM CLEAR: each cycle writes CLR_VAL to Mem[clr_ptr], clr_ptr++; after writing DEPTH-1 -> READY, init_done=1 next cycle.
//   Sweep takes exactly DEPTH cycles after rst_n deasserts. we/re ignored in CLEAR (no write, no dout_valid, no oor_err).
//   rst_n low mid-sweep restarts at clr_ptr=0. Memory contents are NOT cleared by rst_n itself, only by the sweep.
//  FSM READY: stays until rst_n=0. No other transitions.
//  Write: we=1 & wr_addr<DEPTH at edge N -> lanes with be[i]=1 updated at edge N; lanes with be[i]=0 unchanged; be=0 is a no-op.
//  Read: re=1 at edge N -> OUT_REG=0: dout/dout_valid updated at edge N (visible cycle N+1);
//   OUT_REG=1: at edge N+1. Fully pipelined: one read per cycle, back-to-back reads give back-to-back valids.
//  dout holds its last value when no read completes; dout_valid=0 those cycles.
//  Read-during-write, same address, same edge: RDW_MODE=0 -> dout = pre-write word;
//   RDW_MODE=1 -> dout = din on lanes with be=1, old word on lanes with be=0. Different addresses: independent.
//  Read of just-written address on the following cycle always returns new data (both modes).
//  Out of range (addr>=DEPTH, only possible when DEPTH<2**ADDR_W): write dropped; read completes with dout=0, dout_valid=1;
//   oor_err pulses 1 cycle after the offending edge (either port; both in same cycle = single pulse).
//  With OUT_REG=1, rst_n=0 discards in-flight read (no dout_valid after reset).
// TESTING
//  1 Reset, DEPTH=16, CLR_VAL=8'hA5: init_done rises exactly 16 cycles after rst_n=1; read all 16 -> every dout=8'hA5.
//  2 DATA_W=32, write 0x11223344 to addr 3, then be=4'b0101 din=0xAABBCCDD -> read addr 3 = 0x11BB33DD; re during CLEAR -> no dout_valid.
//  3 Same-edge write 0x55 / read addr 7 holding 0x22: RDW_MODE=0 -> dout=0x22; RDW_MODE=1 -> dout=0x55; next read -> 0x55.
//  4 OUT_REG=1, re every cycle addrs 0..5: dout_valid high 6 consecutive cycles starting 2 cycles after first re, data in order.
//  5 DEPTH=12, ADDR_W=4: write addr 13 -> no memory change, oor_err pulse; read addr 14 -> dout=0, dout_valid=1, oor_err=1.
//  6 rst_n low for 1 cycle at sweep count 5 -> init_done stays 0; rises DEPTH cycles after rst_n returns high.

Source files
------------

// File: rtl/dual_port_ram_p.sv
// Simple dual-port RAM: one write port with byte-lane enables, one read port, single clock.
// A hardware sweep loads CLR_VAL into every word after reset; init_done reports the ports are live.
module dual_port_ram_p #(
  parameter int DATA_W   = 8,
  parameter int ADDR_W   = 4,
  parameter int DEPTH    = 16,
  parameter int OUT_REG  = 0,
  parameter int RDW_MODE = 0,
  parameter logic [DATA_W-1:0] CLR_VAL = '0
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   we,
  input  logic [ADDR_W-1:0]      wr_addr,
  input  logic [DATA_W/8-1:0]    be,
  input  logic [DATA_W-1:0]      din,
  input  logic                   re,
  input  logic [ADDR_W-1:0]      re_addr,
  output logic [DATA_W-1:0]      dout,
  output logic                   dout_valid,
  output logic                   oor_err,
  output logic                   init_done
);

  localparam int BE_W = DATA_W / 8;
  localparam logic [ADDR_W:0]   DEPTH_L = (ADDR_W+1)'(DEPTH);
  localparam logic [ADDR_W-1:0] LAST_A  = ADDR_W'(DEPTH - 1);

  typedef enum logic {ST_CLEAR, ST_READY} state_t;

  state_t              state_q, state_d;
  logic [ADDR_W-1:0]   clr_ptr_q, clr_ptr_d;
  logic [DATA_W-1:0]   mem [DEPTH];

  logic                mem_we;
  logic [ADDR_W-1:0]   mem_addr;
  logic [DATA_W-1:0]   mem_wdata;
  logic [BE_W-1:0]     mem_be;

  logic                ready, wr_in, re_in, wr_ok;
  logic                vld_p0, oor_p0;
  logic [DATA_W-1:0]   rd_data_p0;

  function automatic logic [DATA_W-1:0] lane_merge(input logic [DATA_W-1:0] old_w,
                                                   input logic [DATA_W-1:0] new_w,
                                                   input logic [BE_W-1:0]   mask);
    logic [DATA_W-1:0] r;
    r = old_w;
    for (int i = 0; i < BE_W; i++)
      if (mask[i]) r[8*i +: 8] = new_w[8*i +: 8];
    return r;
  endfunction

  assign ready = (state_q == ST_READY);
  assign wr_in = ({1'b0, wr_addr} < DEPTH_L);
  assign re_in = ({1'b0, re_addr} < DEPTH_L);
  assign wr_ok = ready & we & wr_in;

  // The clear sweep owns the write port until the last word is loaded
  always_comb begin
    state_d   = state_q;
    clr_ptr_d = clr_ptr_q;
    mem_we    = 1'b0;
    mem_addr  = wr_addr;
    mem_wdata = din;
    mem_be    = be;
    case (state_q)
      ST_CLEAR: begin
        mem_we    = 1'b1;
        mem_addr  = clr_ptr_q;
        mem_wdata = CLR_VAL;
        mem_be    = '1;
        clr_ptr_d = clr_ptr_q + ADDR_W'(1);
        if (clr_ptr_q == LAST_A) state_d = ST_READY;
      end
      ST_READY: mem_we = wr_ok;
      default:  state_d = ST_CLEAR;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q   <= ST_CLEAR;
      clr_ptr_q <= '0;
      oor_err   <= 1'b0;
    end else begin
      state_q   <= state_d;
      clr_ptr_q <= clr_ptr_d;
      oor_err   <= oor_p0;
    end
  end

  assign init_done = ready;

  always_ff @(posedge clk) begin
    if (rst_n && mem_we)
      for (int i = 0; i < BE_W; i++)
        if (mem_be[i]) mem[mem_addr][8*i +: 8] <= mem_wdata[8*i +: 8];
  end

  // Stage p0: array lookup, out-of-range zeroing and read-during-write bypass
  assign vld_p0 = ready & re;
  assign oor_p0 = ready & ((we & ~wr_in) | (re & ~re_in));

  always_comb begin
    rd_data_p0 = '0;
    if (re_in) begin
      rd_data_p0 = mem[re_addr];
      if (RDW_MODE != 0 && wr_ok && wr_addr == re_addr)
        rd_data_p0 = lane_merge(mem[re_addr], din, be);
    end
  end

  generate
    if (OUT_REG == 0) begin : g_out_direct
      // Stage p1: read data lands on dout
      always_ff @(posedge clk) begin
        if (!rst_n) begin
          dout       <= '0;
          dout_valid <= 1'b0;
        end else begin
          dout_valid <= vld_p0;
          if (vld_p0) dout <= rd_data_p0;
        end
      end
    end else begin : g_out_reg
      logic              vld_p1;
      logic [DATA_W-1:0] rd_data_p1;

      // Stage p1: internal read register
      always_ff @(posedge clk) begin
        if (!rst_n) vld_p1 <= 1'b0;
        else        vld_p1 <= vld_p0;
      end

      always_ff @(posedge clk) begin
        if (vld_p0) rd_data_p1 <= rd_data_p0;
      end

      // Stage p2: output register; reset drops any read still in flight
      always_ff @(posedge clk) begin
        if (!rst_n) begin
          dout       <= '0;
          dout_valid <= 1'b0;
        end else begin
          dout_valid <= vld_p1;
          if (vld_p1) dout <= rd_data_p1;
        end
      end
    end
  endgenerate

endmodule

// File: tb/tb_dual_port_ram_p.sv
// Bench for dual_port_ram_p: four configurations share one stimulus stream, each checked
// every cycle against a word-array model, plus hand-computed literal expectations.
module tb_dual_port_ram_p;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst_n, we, re;
  logic [3:0]  wr_addr, re_addr, be;
  logic [31:0] din;

  logic [3:0][31:0] dout_a;
  logic [3:0]       vld_a, oor_a, init_a;

  int checks   = 0;
  int failures = 0;
  bit armed    = 1'b0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // cfg0: 8b/16 words/lat1/old-data; cfg1: 32b/lat1/new-data; cfg2: 8b/lat2/new-data; cfg3: 32b/12 words/lat2/old-data
  for (genvar g = 0; g < 4; g++) begin : g_cfg
    localparam int DW = (g == 1 || g == 3) ? 32 : 8;
    localparam int BW = DW / 8;
    localparam int DP = (g == 3) ? 12 : 16;
    localparam int OR = (g >= 2) ? 1 : 0;
    localparam int RM = (g == 1 || g == 2) ? 1 : 0;
    localparam logic [31:0] CLR32 = (g == 0) ? 32'hA5 : (g == 1) ? 32'h0 :
                                    (g == 2) ? 32'h5A : 32'h0F0F0F0F;
    localparam logic [31:0] DMASK = (DW == 32) ? 32'hFFFFFFFF : 32'hFF;

    logic [DW-1:0] dout;
    logic          dv, oe, idn;

    dual_port_ram_p #(
      .DATA_W(DW), .ADDR_W(4), .DEPTH(DP), .OUT_REG(OR), .RDW_MODE(RM),
      .CLR_VAL(CLR32[DW-1:0])
    ) u_dut (
      .clk(clk), .rst_n(rst_n), .we(we), .wr_addr(wr_addr), .be(be[BW-1:0]),
      .din(din[DW-1:0]), .re(re), .re_addr(re_addr), .dout(dout),
      .dout_valid(dv), .oor_err(oe), .init_done(idn)
    );

    assign dout_a[g] = 32'(dout);
    assign vld_a[g]  = dv;
    assign oor_a[g]  = oe;
    assign init_a[g] = idn;

    logic [31:0] m [16];
    int          swept;
    bit          rdy, pend_v, e_vld, e_oor, wok;
    logic [31:0] pend_d, e_dout, rd;

    always @(posedge clk) begin
      if (!rst_n) begin
        rdy = 0; swept = 0; pend_v = 0; e_vld = 0; e_oor = 0; e_dout = '0;
      end else if (!rdy) begin
        m[swept] = CLR32 & DMASK;
        swept++;
        if (swept == DP) rdy = 1;
        e_vld = 0;
        e_oor = 0;
      end else begin
        wok = we && (int'(wr_addr) < DP);
        rd  = '0;
        if (re && int'(re_addr) < DP) begin
          rd = m[re_addr];
          if (RM == 1 && wok && wr_addr == re_addr)
            for (int i = 0; i < BW; i++) if (be[i]) rd[8*i +: 8] = din[8*i +: 8];
        end
        e_oor = (we && int'(wr_addr) >= DP) || (re && int'(re_addr) >= DP);
        if (wok)
          for (int i = 0; i < BW; i++) if (be[i]) m[wr_addr][8*i +: 8] = din[8*i +: 8];
        if (OR == 0) begin
          e_vld = re;
          if (re) e_dout = rd;
        end else begin
          e_vld = pend_v;
          if (pend_v) e_dout = pend_d;
          pend_v = re;
          pend_d = rd;
        end
      end
    end

    always @(negedge clk) begin
      if (armed) begin
        chk($sformatf("cfg%0d_valid", g), {31'b0, dv},  {31'b0, e_vld});
        chk($sformatf("cfg%0d_dout", g),  32'(dout),    e_dout);
        chk($sformatf("cfg%0d_oor", g),   {31'b0, oe},  {31'b0, e_oor});
        chk($sformatf("cfg%0d_init", g),  {31'b0, idn}, {31'b0, rdy});
      end
    end
  end

  int rise [4];
  int pat;
  bit any_v;

  task automatic wait_init();
    for (int i = 0; i < 4; i++) rise[i] = 0;
    for (int k = 1; k <= 20; k++) begin
      tick();
      if (k == 10) begin we = 0; re = 0; end
      if (k <= 11 && |vld_a) any_v = 1;
      for (int i = 0; i < 4; i++) if (init_a[i] && rise[i] == 0) rise[i] = k;
    end
  endtask

  initial begin
    rst_n = 0; we = 0; re = 0; wr_addr = 0; re_addr = 0; be = 0; din = 0;
    any_v = 0;
    tick(); armed = 1; tick();
    chk("rst_dout",  dout_a[0], 32'h0);
    chk("rst_valid", {28'b0, vld_a}, 32'h0);
    chk("rst_oor",   {28'b0, oor_a}, 32'h0);
    chk("rst_init",  {28'b0, init_a}, 32'h0);

    // Sweep with both ports hammered: must be ignored
    rst_n = 1; we = 1; wr_addr = 2; be = 4'hF; din = 32'hFFFFFFFF; re = 1; re_addr = 1;
    wait_init();
    chk("sweep_len_d16", rise[0], 16);
    chk("sweep_len_d12", rise[3], 12);
    chk("clear_no_valid", {31'b0, any_v}, 32'h0);

    for (int a = 0; a < 16; a++) begin
      re = 1; re_addr = 4'(a);
      tick();
      if (a == 0) chk("clr_val_a5", dout_a[0], 32'hA5);
      if (a == 2) chk("clr_no_write", dout_a[0], 32'hA5);
    end
    re = 0; tick(); tick();

    // Byte-lane merge
    we = 1; wr_addr = 3; be = 4'hF; din = 32'h11223344; tick();
    be = 4'b0101; din = 32'hAABBCCDD; tick();
    we = 0; re = 1; re_addr = 3; tick();
    re = 0;
    chk("be_merge32", dout_a[1], 32'h11BB33DD);
    chk("be_merge8",  dout_a[0], 32'hDD);
    tick();
    chk("be_merge32_reg", dout_a[3], 32'h11BB33DD);

    // Read-during-write, same address
    we = 1; wr_addr = 7; be = 4'hF; din = 32'h22; tick();
    re = 1; re_addr = 7; din = 32'h55; tick();
    we = 0;
    chk("rdw_old", dout_a[0], 32'h22);
    chk("rdw_new", dout_a[1], 32'h55);
    tick();
    chk("rdw_next_read", dout_a[0], 32'h55);
    chk("rdw_new_reg",   dout_a[2], 32'h55);
    chk("rdw_old_reg",   dout_a[3], 32'h22);
    re = 0; tick();
    chk("rdw_next_reg", dout_a[3], 32'h55);

    // Back-to-back reads through the output register
    pat = 0;
    for (int j = 0; j < 8; j++) begin
      re = (j < 6); re_addr = 4'(j);
      tick();
      if (vld_a[2]) pat |= (1 << j);
      if (j == 1) chk("pipe_first", dout_a[2], 32'h5A);
      if (j == 4) chk("pipe_addr3", dout_a[2], 32'hDD);
    end
    chk("pipe_valid_pattern", pat, 32'h7E);

    // Out-of-range on the 12-word configuration
    we = 1; wr_addr = 13; be = 4'hF; din = 32'hDEADBEEF; tick();
    we = 0;
    chk("oor_wr_pulse", {31'b0, oor_a[3]}, 32'h1);
    chk("oor_wr_inrange", {31'b0, oor_a[0]}, 32'h0);
    re = 1; re_addr = 14; tick();
    re = 0;
    chk("oor_rd_pulse", {31'b0, oor_a[3]}, 32'h1);
    tick();
    chk("oor_rd_clear", {31'b0, oor_a[3]}, 32'h0);
    chk("oor_rd_valid", {31'b0, vld_a[3]}, 32'h1);
    chk("oor_rd_zero",  dout_a[3], 32'h0);
    we = 1; wr_addr = 13; re = 1; re_addr = 15; tick();
    we = 0; re = 0;
    chk("oor_both_pulse", {31'b0, oor_a[3]}, 32'h1);
    tick();
    chk("oor_both_single", {31'b0, oor_a[3]}, 32'h0);
    re = 1; re_addr = 1; tick();
    re_addr = 13; tick();
    chk("oor_no_alias", dout_a[3], 32'h0F0F0F0F);
    re = 0; tick();
    chk("oor_rd13_zero", dout_a[3], 32'h0);
    chk("inrange_wr13",  dout_a[0], 32'hEF);

    // Reset drops in-flight read, then a mid-sweep reset restarts the sweep
    re = 1; re_addr = 0; tick();
    re = 0; rst_n = 0; tick();
    chk("rst_drop_valid", {31'b0, vld_a[2]}, 32'h0);
    chk("rst_drop_dout",  dout_a[2], 32'h0);
    chk("rst_init_low",   {28'b0, init_a}, 32'h0);
    rst_n = 1;
    for (int k = 0; k < 5; k++) tick();
    rst_n = 0; tick();
    chk("restart_init_low", {31'b0, init_a[0]}, 32'h0);
    rst_n = 1;
    wait_init();
    chk("restart_len_d16", rise[0], 16);
    chk("restart_len_d12", rise[3], 12);

    for (int a = 0; a < 16; a++) begin
      re = 1; re_addr = 4'(a);
      tick();
      if (a == 3) chk("resweep_cleared", dout_a[1], 32'h0);
      if (a == 7) chk("resweep_a5", dout_a[0], 32'hA5);
    end
    re = 0; tick(); tick(); tick();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
